// File: rtl/pipelined_barrel_shifter.sv
// Elastic, PIPE-stage barrel shifter (SLL/SRL/SRA/ROL/ROR/pass-through).
// Shift level i (weight 2^i) is applied in stage floor(i*PIPE/SHW); every stage has a valid/ready handshake.
module pipelined_barrel_shifter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned PIPE  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         IData,
   input  logic [$clog2(WIDTH)-1:0] SAmt,
   input  logic [2:0]               SType,
   input  logic                     IValid,
   output logic                     IReady,
   output logic [WIDTH-1:0]         Odata,
   output logic                     OValid,
   input  logic                     OReady
);

   localparam int unsigned SHW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_SLL = 3'b000,
      OP_SRL = 3'b001,
      OP_SRA = 3'b010,
      OP_ROL = 3'b011,
      OP_ROR = 3'b100
   } op_e;

   logic [PIPE-1:0]  r_valid;
   logic [WIDTH-1:0] r_data [PIPE];
   logic [SHW-1:0]   r_amt  [PIPE];
   logic [2:0]       r_type [PIPE];
   logic [PIPE-1:0]  r_sign;

   logic [PIPE-1:0]  w_src_valid;
   logic [WIDTH-1:0] w_src_data [PIPE];
   logic [SHW-1:0]   w_src_amt  [PIPE];
   logic [2:0]       w_src_type [PIPE];
   logic [PIPE-1:0]  w_src_sign;
   logic [WIDTH-1:0] w_next     [PIPE];
   logic [PIPE:0]    w_ready;

   // One shift level by s; SRA fills from the operand's original MSB carried with the item.
   function automatic logic [WIDTH-1:0] f_level(
      input logic [WIDTH-1:0] d,
      input logic [2:0]       op,
      input logic             sgn,
      input int unsigned      s
   );
      logic [WIDTH-1:0] w_fill;
      w_fill = sgn ? ~({WIDTH{1'b1}} >> s) : '0;
      case (op)
         OP_SLL:  f_level = d << s;
         OP_SRL:  f_level = d >> s;
         OP_SRA:  f_level = (d >> s) | w_fill;
         OP_ROL:  f_level = (d << s) | (d >> (WIDTH - s));
         OP_ROR:  f_level = (d >> s) | (d << (WIDTH - s));
         default: f_level = d;
      endcase
   endfunction

   always_comb begin
      w_src_valid   = '0;
      w_src_sign    = '0;
      w_src_valid[0] = IValid;
      w_src_data[0]  = IData;
      w_src_amt[0]   = SAmt;
      w_src_type[0]  = SType;
      w_src_sign[0]  = IData[WIDTH-1];
      for (int unsigned k = 1; k < PIPE; k++) begin
         w_src_valid[k] = r_valid[k-1];
         w_src_data[k]  = r_data[k-1];
         w_src_amt[k]   = r_amt[k-1];
         w_src_type[k]  = r_type[k-1];
         w_src_sign[k]  = r_sign[k-1];
      end

      for (int unsigned k = 0; k < PIPE; k++) begin
         w_next[k] = w_src_data[k];
         for (int unsigned i = 0; i < SHW; i++) begin
            if (((i * PIPE) / SHW) == k && w_src_amt[k][i]) begin
               w_next[k] = f_level(w_next[k], w_src_type[k], w_src_sign[k], 32'd1 << i);
            end
         end
      end

      // Ready ripples back from the output so a full pipeline still advances when OReady is high.
      w_ready       = '0;
      w_ready[PIPE] = OReady;
      for (int unsigned k = PIPE; k > 0; k--) begin
         w_ready[k-1] = !r_valid[k-1] || w_ready[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_sign  <= '0;
         for (int unsigned k = 0; k < PIPE; k++) begin
            r_data[k] <= '0;
            r_amt[k]  <= '0;
            r_type[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < PIPE; k++) begin
            if (w_ready[k]) begin
               r_valid[k] <= w_src_valid[k];
               r_data[k]  <= w_next[k];
               r_amt[k]   <= w_src_amt[k];
               r_type[k]  <= w_src_type[k];
               r_sign[k]  <= w_src_sign[k];
            end
         end
      end
   end

   assign IReady = w_ready[0];
   assign OValid = r_valid[PIPE-1];
   assign Odata  = r_data[PIPE-1];

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the single-cycle shifter in the execute path. It performs logical left, logical right, arithmetic right, rotate left and rotate right on a WIDTH-bit operand. The log2(WIDTH) shift levels are split across PIPE register stages. Each stage uses a valid/ready handshake with backpressure, so the block can sit between decode/issue and writeback in a multi-cycle or pipelined datapath.

Parameters:
WIDTH, 32, operand width in bits; must be a power of two, at least 8.
PIPE, 2, number of registered stages (1..log2(WIDTH)); this is also the latency in cycles.
SHW, log2(WIDTH) (derived localparam, not overridable), shift-amount width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
IData  in  WIDTH  operand.
SAmt  in  SHW  shift amount, 0..WIDTH-1.
SType  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101..111 pass-through.
IValid  in  1  input transfer request.
IReady  out  1  block can accept an input this cycle.
Odata  out  WIDTH  result.
OValid  out  1  Odata holds a valid result.
OReady  in  1  downstream accepts the result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid flags clear, so OValid=0;
  - all data, amount and type registers clear, so Odata=0;
  - IReady=1 as soon as reset is released.
  - Reset asserted mid-operation discards all in-flight items, with no partial output.
- Transfer rules:
  - Input transfer occurs when IValid && IReady at a rising edge.
  - Output transfer occurs when OValid && OReady at a rising edge.
- Stage registers: each stage k (0..PIPE-1) holds valid_k, data_k, the residual amount and SType.
- Elastic pipeline:
  - ready_k = !valid_k || ready_(k+1), with ready_PIPE = OReady;
  - IReady = ready_0, combinational from OReady through the chain.
  - Stage k loads whenever ready_k is high. On a load, valid_k takes the upstream valid.
- Throughput and latency:
  - Full throughput is 1 item/cycle with OReady held high.
  - Latency is exactly PIPE cycles from input transfer to OValid with no stalls.
- Ordering: results emerge in input order; no reordering, dropping or duplication.
- Backpressure:
  - While OValid && !OReady, Odata and OValid hold stable.
  - Upstream stages fill. When all stages are valid, IReady=0.
- Level partitioning:
  - Level i (weight 2^i, i=0..SHW-1) is applied in stage floor(i*PIPE/SHW).
  - Within a stage, levels apply in ascending i.
  - Level i shifts by 2^i if SAmt[i]=1 and passes through otherwise.
- Fill rules:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with the original IData[WIDTH-1], carried with the item, not the intermediate MSB.
  - ROL/ROR: wrap-around, so ROL by n equals ROR by WIDTH-n.
  - Pass-through codes: Odata = IData unchanged.
- Arithmetic: the shift amount is taken modulo WIDTH by construction. SAmt=0 returns IData for every SType.
- Simultaneous events: input and output transfers in the same cycle are legal when full, so the pipeline stays full with no bubble.
- Data registers load only on a stage load. Stalled stages must not change.

Test Plan:
- WIDTH=32, PIPE=2:
  - IData=0x8000_00F1, SAmt=4, SType=SRA -> Odata=0xF800_000F exactly 2 cycles after transfer.
  - Same operand, SType=SRL -> 0x0800_000F.
  - SType=SLL, SAmt=31, IData=1 -> 0x8000_0000.
- Rotates: IData=0x1234_5678, SAmt=8:
  - ROL -> 0x3456_7812.
  - ROR -> 0x7812_3456.
  - SAmt=0 any type -> 0x1234_5678.
  - SType=111 -> 0x1234_5678.
- Backpressure: stream 6 items with OReady=0 for cycles 3-7.
  - IReady drops once 2 items are held.
  - Odata stays stable while stalled.
  - All 6 results arrive in order with no loss once OReady=1.
- Throughput: 100 random items with IValid=OReady=1 continuously.
  - One result per cycle after 2-cycle fill.
  - Every result matches the reference model.
- Reset mid-flight: assert rst_n=0 asynchronously with 2 items in flight.
  - OValid=0 and Odata=0 immediately, without waiting for a clock edge.
  - No stale result after release.
  - IReady=1.
- Parameter sweep: WIDTH=8/PIPE=3 and WIDTH=64/PIPE=1.
  - Latency equals PIPE.
  - Random SLL/SRL/SRA/ROL/ROR results match the model; example WIDTH=8: 0x96 SRA 3 -> 0xF2.
